// File: rtl/mem_responder.sv
// Byte-wide memory responder behind the CPU MR/MW strobes; services one access per strobe fall.
// Build option: define MEM_RESPONDER_WAIT_STATE_EN for a 2-cycle read with READY low in RD_WAIT.
module mem_responder #(
  parameter int                ADDR_W = 16,
  parameter int                DEPTH  = 256,
  parameter logic [ADDR_W-1:0] BASE   = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              MR,
  input  logic              MW,
  input  logic [7:0]        DIN,
  output logic [7:0]        DOUT,
  output logic              DVALID,
  output logic              READY,
  output logic              ERR,
  output logic [2:0]        dbg_state
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_HOLD  = 3'd2,
    S_WR_HOLD  = 3'd3,
    S_ERR_HOLD = 3'd4
  } state_t;

  // Strobe protocol: MR/MW are active-low levels. An access starts only on the
  // first IDLE sample where a strobe is low after a sample with both strobes
  // high; it completes when that strobe is sampled high again. Both strobes low
  // together is a protocol error held until both are high.

  logic [7:0]       mem [DEPTH];
  state_t           state_q, state_d;
  logic [7:0]       dout_q;
  logic             armed_q;
  logic [ADDR_W:0]  offset;
  logic             hit;
  logic             both_low;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd_idx;
  logic             mem_we;
  logic             dout_load;
`ifdef MEM_RESPONDER_WAIT_STATE_EN
  logic [IDX_W-1:0] rd_idx_q;
  logic             idx_latch;
`endif

  // An address below BASE wraps into the top bit and therefore fails the range test.
  assign offset   = {1'b0, ADDR} - {1'b0, BASE};
  assign hit      = (offset < DEPTH_V);
  assign idx      = offset[IDX_W-1:0];
  assign both_low = !MR && !MW;

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    dout_load = 1'b0;
    rd_idx    = idx;
`ifdef MEM_RESPONDER_WAIT_STATE_EN
    idx_latch = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (both_low) begin
          state_d = S_ERR_HOLD;
        end else if (armed_q && hit && !MR) begin
`ifdef MEM_RESPONDER_WAIT_STATE_EN
          state_d   = S_RD_WAIT;
          idx_latch = 1'b1;
`else
          state_d   = S_RD_HOLD;
          dout_load = 1'b1;
`endif
        end else if (armed_q && hit && !MW) begin
          state_d = S_WR_HOLD;
          mem_we  = 1'b1;
        end
      end
`ifdef MEM_RESPONDER_WAIT_STATE_EN
      S_RD_WAIT: begin
        if (both_low) begin
          state_d = S_ERR_HOLD;
        end else begin
          state_d   = S_RD_HOLD;
          dout_load = 1'b1;
          rd_idx    = rd_idx_q;
        end
      end
`endif
      S_RD_HOLD: begin
        if (both_low) state_d = S_ERR_HOLD;
        else if (MR)  state_d = S_IDLE;
      end
      S_WR_HOLD: begin
        if (both_low) state_d = S_ERR_HOLD;
        else if (MW)  state_d = S_IDLE;
      end
      S_ERR_HOLD: begin
        if (MR && MW) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (dout_load) dout_q <= mem[rd_idx];
    end
  end

  // Tracks strobe levels even during reset so a strobe still low at release is ignored.
  always_ff @(posedge clock) begin
    armed_q <= MR && MW;
  end

  // Array contents survive reset; only the write is suppressed while reset is low.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem[idx] <= DIN;
  end

`ifdef MEM_RESPONDER_WAIT_STATE_EN
  always_ff @(posedge clock) begin
    if (idx_latch) rd_idx_q <= idx;
  end
  assign READY = (state_q != S_RD_WAIT);
`else
  assign READY = 1'b1;
`endif

  assign DOUT      = dout_q;
  assign DVALID    = (state_q == S_RD_HOLD);
  assign ERR       = (state_q == S_ERR_HOLD);
  assign dbg_state = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, width of the CPU address bus.
REQ-002 Parameter DEPTH, default 256, number of 8-bit words in the internal array.
REQ-003 Parameter BASE, default 16'h0000, first address decoded by this block.
REQ-004 clock  in  1  single clock for all state; everything SHALL update on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 ADDR  in  ADDR_W  address from PC, MA (MAH:MAL) or SP.
REQ-007 MR  in  1  active-low memory read strobe.
REQ-008 MW  in  1  active-low memory write strobe.
REQ-009 DIN  in  8  write data from the CPU data bus.
REQ-010 DOUT  out  8  read data toward the MD/AC latch.
REQ-011 DVALID  out  1  DOUT holds valid read data.
REQ-012 READY  out  1  high when the responder can complete the current strobe.
REQ-013 ERR  out  1  strobe protocol violation flag.

Function
REQ-014 Hit: ADDR is in BASE..BASE+DEPTH-1, index = ADDR-BASE, truncated to clog2(DEPTH) bits.
REQ-015 States: IDLE, RD_WAIT, RD_HOLD, WR_HOLD, ERR_HOLD.
REQ-016 IDLE with MR=0, MW=1, hit: the address SHALL be latched and the FSM SHALL go to RD_HOLD, loading DOUT<=mem[index] and setting DVALID=1, so data is valid 1 cycle after the first sampled MR-low edge.
REQ-017 RD_HOLD: DOUT and DVALID SHALL hold while MR=0, with no re-read even if ADDR changes; when MR=1 is sampled, the FSM SHALL go to IDLE with DVALID=0 and DOUT holding its last value.
REQ-018 IDLE with MW=0, MR=1, hit: mem[index]<=DIN SHALL occur on that same edge, then the FSM SHALL go to WR_HOLD.
REQ-019 WR_HOLD: no further writes while MW=0, so exactly one write per strobe; when MW=1 is sampled, the FSM SHALL go to IDLE.
REQ-020 Miss on either strobe: no array access, DVALID stays 0, and the FSM SHALL stay in IDLE until the strobes are high, then re-evaluate on the next falling strobe.
REQ-021 MR=0 and MW=0 on the same sample, in any state: the FSM SHALL go to ERR_HOLD with ERR=1 and no array access; it SHALL leave to IDLE with ERR=0 only when MR=1 and MW=1 are sampled.
REQ-022 In RD_HOLD, MW falling with MR=0 SHALL be treated as REQ-021; in WR_HOLD, MR falling likewise.
REQ-023 A read strobe immediately after a write strobe to the same address SHALL return the newly written byte.
REQ-024 READY SHALL be 1 in every state except RD_WAIT.

Reset
REQ-025 reset=0 at an edge SHALL force IDLE, DOUT=8'h00, DVALID=0, READY=1 and ERR=0, including mid-strobe.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 After reset release, a strobe already low SHALL NOT be serviced; the FSM SHALL wait for MR=1 and MW=1 first.

Configuration
REQ-028 Macro MEM_RESPONDER_WAIT_STATE_EN.
- Defined: a read hit SHALL go IDLE->RD_WAIT with READY=0 and DVALID=0 for 1 cycle, then RD_WAIT->RD_HOLD loading DOUT, so read latency is 2 cycles. Writes are unchanged.
- Undefined: RD_WAIT SHALL not exist and READY SHALL be constant 1.

Verification
REQ-029 Reset, write ADDR=16'h0010 DIN=8'hA5 with MW low 1 cycle, then read 16'h0010 with MR low 2 cycles -> DVALID=1 and DOUT=8'hA5 in the 2nd MR-low cycle (3rd with WAIT_STATE_EN); DVALID=0 after MR high.
REQ-030 Hold MW low 3 cycles at 16'h0020 while DIN changes 11->22->33 -> mem[0x20]=8'h11.
REQ-031 Read 16'h0100 with DEPTH=256, BASE=0 -> DVALID stays 0 and no array change.
REQ-032 MR=0 and MW=0 together -> ERR=1 next cycle, held until both high; array unchanged.
REQ-033 Assert reset in RD_HOLD with MR still low -> DOUT=00 and DVALID=0; no new read until MR rises and falls again.
REQ-034 Change ADDR mid-read from 0x10 to 0x11 -> DOUT stays mem[0x10] for the whole strobe.
